// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its serial receiver:
// receiver state encoding, default word width and the serial line idle level.
package usr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } usr_state_e;

  localparam int   USR_WIDTH = 4;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/usr_serial_rx.sv
// Strobe-sampled serial receiver: start bit, WIDTH data bits, optional even parity,
// stop bit; each frame lands in a valid/ready output register with error status.
module usr_serial_rx
  import usr_pkg::*;
#(
  parameter int WIDTH     = USR_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             SERIAL_IN,
  input  logic             BIT_EN,
  output logic [0:WIDTH-1] DATA_OUT,
  output logic             DATA_VALID,
  input  logic             DATA_READY,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             OVERRUN,
  output logic             BUSY
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  usr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:WIDTH-1] shift_q, shift_d;
  logic             perr_int_q, perr_int_d;
  logic             ferr_int_q, ferr_int_d;
  logic             commit_q, commit_d;

  logic [0:WIDTH-1] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  // Frame FSM: every transition is gated by the bit strobe.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    perr_int_d = perr_int_q;
    ferr_int_d = ferr_int_q;
    commit_d   = 1'b0;
    if (BIT_EN) begin
      case (state_q)
        ST_IDLE: begin
          if (SERIAL_IN != LINE_IDLE) begin
            state_d    = ST_DATA;
            cnt_d      = '0;
            perr_int_d = 1'b0;
          end
        end
        ST_DATA: begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) shift_d[i] = SERIAL_IN;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = PARITY_EN ? ST_PARITY : ST_STOP;
        end
        ST_PARITY: begin
          perr_int_d = ^{shift_q, SERIAL_IN};
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          ferr_int_d = (SERIAL_IN != LINE_IDLE);
          commit_d   = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The commit lands one edge after the stop sample; a full, undrained register drops it.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (commit_q) begin
      if (!valid_q || DATA_READY) begin
        data_d  = shift_q;
        perr_d  = PARITY_EN ? perr_int_q : 1'b0;
        ferr_d  = ferr_int_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && DATA_READY) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      perr_int_q <= 1'b0;
      ferr_int_q <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else if (!CLR) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      perr_int_q <= 1'b0;
      ferr_int_q <= 1'b0;
      commit_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      perr_int_q <= perr_int_d;
      ferr_int_q <= ferr_int_d;
      commit_q   <= commit_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign DATA_OUT   = data_q;
  assign DATA_VALID = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign OVERRUN    = ovr_q;
  assign BUSY       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usr_serial_rx.sv
// Directed bench for usr_serial_rx: a parity build and a no-parity build,
// expected words queued as frames are sent and popped when DATA_VALID shows.
module tb_usr_serial_rx;

  localparam int W = 4;

  typedef struct packed {
    logic [0:W-1] data;
    logic         perr;
    logic         ferr;
  } exp_t;

  logic         CLK = 1'b0;
  logic         RST, CLR;
  logic         SERIAL_IN, BIT_EN, DATA_READY;
  logic [0:W-1] DATA_OUT;
  logic         DATA_VALID, PARITY_ERR, FRAME_ERR, OVERRUN, BUSY;

  logic         ser_np, en_np, ready_np;
  logic [0:W-1] data_np;
  logic         valid_np, perr_np, ferr_np, ovr_np, busy_np;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;
  int   failed = 0;

  usr_serial_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .SERIAL_IN(SERIAL_IN), .BIT_EN(BIT_EN),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .PARITY_ERR(PARITY_ERR), .FRAME_ERR(FRAME_ERR), .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  usr_serial_rx #(.WIDTH(W), .PARITY_EN(1'b0)) dut_np (
    .CLK(CLK), .RST(RST), .CLR(CLR), .SERIAL_IN(ser_np), .BIT_EN(en_np),
    .DATA_OUT(data_np), .DATA_VALID(valid_np), .DATA_READY(ready_np),
    .PARITY_ERR(perr_np), .FRAME_ERR(ferr_np), .OVERRUN(ovr_np), .BUSY(busy_np)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Two quiet cycles then a one-cycle strobe; returns 1ns after the sampling edge.
  task automatic strobe(input logic b, input bit np);
    repeat (2) @(posedge CLK);
    #1;
    if (np) begin ser_np = b; en_np = 1'b1; end
    else begin SERIAL_IN = b; BIT_EN = 1'b1; end
    @(posedge CLK);
    #1;
    BIT_EN = 1'b0; en_np = 1'b0;
    SERIAL_IN = 1'b1; ser_np = 1'b1;
  endtask

  task automatic send_frame(input logic [0:W-1] d, input logic pbit, input logic stop,
                            input bit np, input bit push);
    exp_t e;
    strobe(1'b0, np);
    for (int i = 0; i < W; i++) strobe(d[i], np);
    if (!np) strobe(pbit, np);
    strobe(stop, np);
    if (push) begin
      e.data = d;
      e.perr = np ? 1'b0 : ^{d, pbit};
      e.ferr = ~stop;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_pop(input string tag, input bit np);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s_sb: observed empty scoreboard expected a queued word", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, np ? valid_np : DATA_VALID, 1);
      check({tag, "_data"},  np ? data_np  : DATA_OUT,   e.data);
      check({tag, "_perr"},  np ? perr_np  : PARITY_ERR, e.perr);
      check({tag, "_ferr"},  np ? ferr_np  : FRAME_ERR,  e.ferr);
    end
  endtask

  task automatic drain(input string tag);
    DATA_READY = 1'b1;
    @(posedge CLK);
    #1;
    DATA_READY = 1'b0;
    check({tag, "_drained"}, DATA_VALID, 0);
  endtask

  initial begin
    RST = 1'b0; CLR = 1'b1;
    SERIAL_IN = 1'b1; BIT_EN = 1'b0; DATA_READY = 1'b0;
    ser_np = 1'b1; en_np = 1'b0; ready_np = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_data",  DATA_OUT, 0);
    check("rst_valid", DATA_VALID, 0);
    check("rst_flags", {PARITY_ERR, FRAME_ERR, OVERRUN, BUSY}, 0);
    check("rst_np",    {data_np, valid_np, ovr_np, busy_np}, 0);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Clean frame: valid must not appear on the stop edge itself, only one edge later.
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1);
    check("clean_latency", DATA_VALID, 0);
    check("clean_idle", BUSY, 0);
    @(posedge CLK);
    #1;
    check_pop("clean", 0);
    drain("clean");

    // Bad parity and bad stop bit are delivered with both flags.
    send_frame(4'b1011, 1'b0, 1'b0, 0, 1);
    @(posedge CLK);
    #1;
    check_pop("errs", 0);
    drain("errs");

    // Overrun: second frame dropped while the first is held.
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1);
    @(posedge CLK);
    #1;
    check_pop("ovr_first", 0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 0);
    @(posedge CLK);
    #1;
    check("ovr_held", DATA_OUT, 4'b1011);
    check("ovr_valid", DATA_VALID, 1);
    check("ovr_flag", OVERRUN, 1);
    CLR = 1'b0;
    @(posedge CLK);
    #1;
    CLR = 1'b1;
    check("clr_ovr", OVERRUN, 0);
    check("clr_valid", DATA_VALID, 0);

    // Simultaneous drain and fill on the commit edge.
    send_frame(4'b1011, 1'b1, 1'b1, 0, 1);
    @(posedge CLK);
    #1;
    check_pop("sim_first", 0);
    send_frame(4'b0110, 1'b0, 1'b1, 0, 1);
    DATA_READY = 1'b1;
    @(posedge CLK);
    #1;
    DATA_READY = 1'b0;
    check_pop("sim_second", 0);
    check("sim_ovr", OVERRUN, 0);

    // Asynchronous reset mid-frame while a word is still held.
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b0, 0);
    check("mid_busy", BUSY, 1);
    #2 RST = 1'b0;
    #1;
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_valid", DATA_VALID, 0);
    check("mid_rst_data", DATA_OUT, 0);
    check("mid_rst_flags", {PARITY_ERR, FRAME_ERR, OVERRUN}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    send_frame(4'b1001, 1'b0, 1'b1, 0, 1);
    @(posedge CLK);
    #1;
    check_pop("after_rst", 0);
    drain("after_rst");

    // Low line without strobes must not start a frame.
    SERIAL_IN = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      check("gate_busy", BUSY, 0);
    end
    SERIAL_IN = 1'b1;

    // No-parity build: stop follows the last data bit directly.
    send_frame(4'b1100, 1'b0, 1'b1, 1, 1);
    check("np_latency", valid_np, 0);
    @(posedge CLK);
    #1;
    check_pop("np", 1);
    check("np_ovr", ovr_np, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/usr_serial_rx.md
Name: usr_serial_rx

Overview:
- Downstream consumer of the universal shift register's serial output.
- Samples the serial stream on an external bit-strobe and frames it: start bit, WIDTH data bits, optional even parity, stop bit.
- Assembles each frame into a parallel word, delivered through a valid/ready output register with parity, framing and overrun status.
- Sits between the shift register's SERIAL_OUT and any parallel sink (display, register file, second shift register's PARALLEL_INPUT).

Parameters:
WIDTH, 4, data bits per frame (>=1)
PARITY_EN, 1, 1 = even-parity bit follows the data bits; 0 = no parity bit

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  reset, asynchronous, active-low
CLR  input  1  synchronous clear, active-low
SERIAL_IN  input  1  serial line; idle level 1
BIT_EN  input  1  one-cycle strobe; SERIAL_IN is sampled only in cycles where BIT_EN=1
DATA_OUT  output  WIDTH ([0:WIDTH-1])  received word; first data bit received -> DATA_OUT[0]
DATA_VALID  output  1  DATA_OUT and status flags hold a word
DATA_READY  input  1  sink accepts the word when DATA_VALID & DATA_READY
PARITY_ERR  output  1  parity mismatch for the held word (0 when PARITY_EN=0)
FRAME_ERR  output  1  stop bit sampled as 0 for the held word
OVERRUN  output  1  sticky: a completed frame was dropped because the output register was full
BUSY  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset: RST=0 forces the FSM to IDLE and clears the bit counter and shift register. All outputs go to 0 (DATA_OUT=0, DATA_VALID=0, flags 0, BUSY=0).
- Priority: RST > CLR > normal operation.
- CLR=0 on a clock edge has the same effect as reset, applied synchronously, including clearing OVERRUN.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: BIT_EN & SERIAL_IN=0 -> DATA, bit count=0. BIT_EN & SERIAL_IN=1 -> stay in IDLE.
- DATA: each BIT_EN shifts SERIAL_IN into position count, then count++. After the sample that completes WIDTH bits:
  - PARITY_EN=1 -> PARITY
  - PARITY_EN=0 -> STOP
- PARITY: BIT_EN samples the parity bit. The error is latched internally if XOR(data bits, parity bit)=1. -> STOP.
- STOP: BIT_EN samples the stop bit. The frame is committed and the FSM returns to IDLE. FRAME_ERR for the frame = ~SERIAL_IN.
- Frames with parity or framing errors are still delivered, with their flags set.
- BIT_EN=0 cycles: no state change in any state. There is no timeout.
- Commit: the output register loads {word, PARITY_ERR, FRAME_ERR} and sets DATA_VALID=1 when either:
  - DATA_VALID=0, or
  - DATA_VALID & DATA_READY in the same cycle (simultaneous drain and fill). The new word is visible the next cycle and DATA_VALID stays high.
- Commit while the register is full: if DATA_VALID=1 & DATA_READY=0 at commit, the new frame is dropped, OVERRUN sets and the held word is untouched.
- Latency: DATA_VALID rises on the edge after the clock edge at which the stop-bit BIT_EN is sampled.
- Handshake:
  - DATA_OUT, PARITY_ERR and FRAME_ERR are stable while DATA_VALID=1.
  - DATA_VALID & DATA_READY with no commit -> DATA_VALID=0 next cycle.
  - DATA_READY while DATA_VALID=0 has no effect.
- OVERRUN: cleared only by RST or CLR.
- BUSY=1 in DATA, PARITY and STOP.
- Back-to-back frames: the next start bit needs a later BIT_EN. The stop-bit strobe is never reused as a start.
- Reset or CLR mid-frame: the partial frame is discarded and no word is committed.

Decomposition:
- Shared package usr_pkg: state encoding constants (IDLE/DATA/PARITY/STOP), the default WIDTH=4, and the line idle level.
- The shift register and this receiver both use WIDTH from the package.
- No sub-module. Parity is a reduction XOR inline. The bit counter width is $clog2(WIDTH+1).

Test Plan:
- Clean frame (WIDTH=4, PARITY_EN=1): BIT_EN each 3rd cycle, bits 0,1,0,1,1,1,1 -> DATA_OUT=4'b1011 (index 0 first), DATA_VALID=1 one cycle after the stop strobe, PARITY_ERR=0, FRAME_ERR=0; DATA_READY=1 -> DATA_VALID=0 next cycle.
- Parity and framing errors: bits 0,1,0,1,1,0,0 -> DATA_OUT=4'b1011, PARITY_ERR=1, FRAME_ERR=1, DATA_VALID=1.
- Overrun: two clean frames (1011, then 0110 with parity 0) with DATA_READY=0 -> DATA_OUT stays 1011, OVERRUN=1; CLR=0 for one cycle -> OVERRUN=0, DATA_VALID=0.
- Simultaneous drain and fill: hold DATA_READY=1 on the commit cycle of the second frame -> DATA_VALID stays 1, DATA_OUT=0110, OVERRUN=0.
- Mid-frame reset: assert RST=0 asynchronously after 2 data bits -> BUSY=0 and all outputs 0 immediately; the next clean frame 1,0,0,1 (parity 0) is received correctly as 4'b1001.
- Idle and strobe gating: SERIAL_IN=0 with BIT_EN=0 for 10 cycles -> BUSY stays 0. PARITY_EN=0 build: bits 0,1,1,0,0,1 -> DATA_OUT=4'b1100, PARITY_ERR=0.
